mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width; the block SHALL support only 32 and 64.
REQ-002 Parameter RA_W, 5, register-address width.
REQ-003 Parameter CNT_W, 32, retire-counter width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold the stage contents.
REQ-007 flush  input  1  insert a bubble.
REQ-008 in_valid  input  1  the MEM-stage slot holds an instruction.
REQ-009 in_regwrite  input  1  the instruction writes rd.
REQ-010 in_rd  input  RA_W  destination register.
REQ-011 in_wb_sel  input  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-012 in_alu_result, in_mem_data, in_pc_plus4, in_imm  input  XLEN each  candidate writeback values.
REQ-013 in_load_size  input  2  load size: 00 byte, 01 half, 10 word, 11 full XLEN.
REQ-014 in_load_unsigned  input  1  zero-extend when 1, sign-extend when 0.
REQ-015 in_byte_off  input  log2(XLEN/8)  byte offset of the load within in_mem_data.
REQ-016 wb_valid  output  1  registered valid.
REQ-017 wb_regwrite  output  1  registered register-file write enable.
REQ-018 wb_rd  output  RA_W  registered destination register.
REQ-019 wb_data  output  XLEN  registered writeback value.
REQ-020 instret  output  CNT_W  retired-instruction count.

Function
REQ-021 Source select and load extension SHALL be combinational ahead of the register; wb_* SHALL appear exactly 1 cycle after capture.
REQ-022 Load extraction for wb_sel=01:
- byte: lane in_byte_off, bits [8*off+7 : 8*off].
- half: lane in_byte_off with bit0 ignored.
- word: lane in_byte_off with bits [1:0] ignored.
- size 11: all of in_mem_data.
REQ-023 The extracted field SHALL be extended to XLEN: zero-extended when in_load_unsigned=1, otherwise sign-extended from its top bit; for size 11, in_load_unsigned SHALL have no effect.
REQ-024 On XLEN=32, size 11 SHALL be identical to word.
REQ-025 in_load_size, in_load_unsigned and in_byte_off SHALL have no effect unless wb_sel=01.
REQ-026 Capture (stall=0, flush=0):
- wb_valid <= in_valid.
- wb_rd <= in_rd.
- wb_data <= the selected value.
- wb_regwrite <= in_valid & in_regwrite & (in_rd != 0).
REQ-027 Writes to register x0 SHALL never assert wb_regwrite.
REQ-028 With stall=1 and flush=0, all wb_* registers SHALL hold their values.
REQ-029 With flush=1, regardless of stall, the next edge SHALL load wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0.
REQ-030 instret SHALL increment by 1 on every edge that captures with in_valid=1 (stall=0, flush=0), independent of in_regwrite.
REQ-031 instret SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-032 A stalled or flushed cycle SHALL NOT increment instret.
REQ-033 With in_valid=0 and capture, wb_valid=0 and wb_regwrite=0; wb_data SHALL still load the selected value (don't-care to consumers).

Reset
REQ-034 reset=1 SHALL immediately, without waiting for a clock edge, force wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0 and instret=0.
REQ-035 Reset asserted mid-stall or mid-flush SHALL take priority over both.
REQ-036 The first capture SHALL occur on the first rising edge with reset=0.

Verification
REQ-037 The bench SHALL cover the following scenarios:
- S1: XLEN=32; wb_sel=01, in_mem_data=0x80FF7F01, size byte, off=2, unsigned=0 -> wb_data=0xFFFFFFFF next cycle; same stimulus with unsigned=1 -> 0x000000FF.
- S2: XLEN=64; size word, off=4, unsigned=0, in_mem_data=0x9000000012345678 -> wb_data=0xFFFFFFFF90000000; size 11 -> 0x9000000012345678.
- S3: in_regwrite=1, in_rd=0, wb_sel=00, alu=0x1234 -> wb_valid=1, wb_regwrite=0, wb_data=0x1234, instret +1.
- S4: capture valid rd=5, then stall 3 cycles with changing inputs -> wb_* unchanged and instret unchanged; then flush with stall=1 -> wb_valid=0, wb_regwrite=0, wb_data=0.
- S5: CNT_W=4; 16 valid captures -> instret wraps 15->0; assert reset asynchronously between edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback source, extracts and extends load data,
// and counts retired instructions.
module mem_wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic                       in_regwrite,
  input  logic [RA_W-1:0]            in_rd,
  input  logic [1:0]                 in_wb_sel,
  input  logic [XLEN-1:0]            in_alu_result,
  input  logic [XLEN-1:0]            in_mem_data,
  input  logic [XLEN-1:0]            in_pc_plus4,
  input  logic [XLEN-1:0]            in_imm,
  input  logic [1:0]                 in_load_size,
  input  logic                       in_load_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]  in_byte_off,
  output logic                       wb_valid,
  output logic                       wb_regwrite,
  output logic [RA_W-1:0]            wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic [CNT_W-1:0]           instret
);

  localparam int unsigned OffW = $clog2(XLEN / 8);

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("mem_wb_stage: XLEN must be 32 or 64");
  end

  logic [OffW-1:0] lane_off;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] sel_val;

  logic            valid_q,    valid_d;
  logic            regwrite_q, regwrite_d;
  logic [RA_W-1:0] rd_q,       rd_d;
  logic [XLEN-1:0] data_q,     data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Sub-word loads are naturally aligned: drop the low offset bits below the access size.
  always_comb begin
    lane_off = '0;
    unique case (in_load_size)
      2'b00:   lane_off = in_byte_off;
      2'b01:   lane_off = in_byte_off & ~OffW'(1);
      2'b10:   lane_off = in_byte_off & ~OffW'(3);
      default: lane_off = '0;
    endcase
    lane_data = in_mem_data >> {lane_off, 3'b000};
  end

  always_comb begin
    load_val = lane_data;
    unique case (in_load_size)
      2'b00: begin
        if (in_load_unsigned) load_val = XLEN'(lane_data[7:0]);
        else                  load_val = XLEN'(signed'(lane_data[7:0]));
      end
      2'b01: begin
        if (in_load_unsigned) load_val = XLEN'(lane_data[15:0]);
        else                  load_val = XLEN'(signed'(lane_data[15:0]));
      end
      2'b10: begin
        if (in_load_unsigned) load_val = XLEN'(lane_data[31:0]);
        else                  load_val = XLEN'(signed'(lane_data[31:0]));
      end
      default: load_val = lane_data;
    endcase
  end

  always_comb begin
    sel_val = in_alu_result;
    unique case (in_wb_sel)
      2'b00:   sel_val = in_alu_result;
      2'b01:   sel_val = load_val;
      2'b10:   sel_val = in_pc_plus4;
      default: sel_val = in_imm;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    data_d     = data_q;
    instret_d  = instret_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      data_d     = '0;
    end else if (!stall) begin
      valid_d    = in_valid;
      regwrite_d = in_valid & in_regwrite & (in_rd != '0);
      rd_d       = in_rd;
      data_d     = sel_val;
      if (in_valid) instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      instret_q  <= instret_d;
    end
  end

  assign wb_valid    = valid_q;
  assign wb_regwrite = regwrite_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage: a 32-bit instance with a 4-bit retire
// counter and a 64-bit instance, both checked against a byte-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_regwrite = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [1:0]  in_load_size = '0;
  logic        in_load_unsigned = 1'b0;
  logic [63:0] alu = '0, mem = '0, pc4 = '0, imm = '0;
  logic [2:0]  off = '0;

  logic        v32, rw32, v64, rw64;
  logic [4:0]  rd32, rd64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  ir32;
  logic [31:0] ir64;

  int checks = 0;
  int failures = 0;

  // Reference state, index 0 = 32-bit instance, 1 = 64-bit instance
  logic        m_valid [2];
  logic        m_rw    [2];
  logic [4:0]  m_rd    [2];
  logic [63:0] m_data  [2];
  int unsigned m_ret   [2];

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(4)) u_dut32 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(alu[31:0]), .in_mem_data(mem[31:0]), .in_pc_plus4(pc4[31:0]),
    .in_imm(imm[31:0]), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_byte_off(off[1:0]),
    .wb_valid(v32), .wb_regwrite(rw32), .wb_rd(rd32), .wb_data(d32), .instret(ir32)
  );

  mem_wb_stage #(.XLEN(64), .RA_W(5), .CNT_W(32)) u_dut64 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(alu), .in_mem_data(mem), .in_pc_plus4(pc4),
    .in_imm(imm), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_byte_off(off),
    .wb_valid(v64), .wb_regwrite(rw64), .wb_rd(rd64), .wb_data(d64), .instret(ir64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Load value from plain byte arithmetic: size in bytes, aligned start, mask, extend.
  function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] m,
                                           input logic [1:0] size, input logic [2:0] o,
                                           input logic uns);
    int nb, start, offv;
    logic [63:0] full, mask, v;
    full = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    offv = (xlen == 64) ? int'(o) : int'(o) % 4;
    case (size)
      2'd0: nb = 1;
      2'd1: nb = 2;
      2'd2: nb = 4;
      default: nb = xlen / 8;
    endcase
    start = (offv / nb) * nb;
    mask  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v     = ((m & full) >> (8 * start)) & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    return v & full;
  endfunction

  function automatic logic [63:0] ref_sel(input int xlen);
    logic [63:0] full;
    full = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (in_wb_sel)
      2'd0: return alu & full;
      2'd1: return ref_load(xlen, mem, in_load_size, off, in_load_unsigned);
      2'd2: return pc4 & full;
      default: return imm & full;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_rw[d] = 1'b0; m_rd[d] = '0; m_data[d] = '0; m_ret[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        m_valid[d] = 1'b0; m_rw[d] = 1'b0; m_rd[d] = '0; m_data[d] = '0;
      end else if (!stall) begin
        m_valid[d] = in_valid;
        m_rw[d]    = in_valid && in_regwrite && (in_rd != 0);
        m_rd[d]    = in_rd;
        m_data[d]  = ref_sel(d == 0 ? 32 : 64);
        if (in_valid) m_ret[d] = m_ret[d] + 1;
      end
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".v32"},   {63'd0, v32},  {63'd0, m_valid[0]});
    check({pfx, ".rw32"},  {63'd0, rw32}, {63'd0, m_rw[0]});
    check({pfx, ".rd32"},  {59'd0, rd32}, {59'd0, m_rd[0]});
    check({pfx, ".d32"},   {32'd0, d32},  m_data[0]);
    check({pfx, ".ir32"},  {60'd0, ir32}, 64'(m_ret[0] % 16));
    check({pfx, ".v64"},   {63'd0, v64},  {63'd0, m_valid[1]});
    check({pfx, ".rw64"},  {63'd0, rw64}, {63'd0, m_rw[1]});
    check({pfx, ".rd64"},  {59'd0, rd64}, {59'd0, m_rd[1]});
    check({pfx, ".d64"},   d64,           m_data[1]);
    check({pfx, ".ir64"},  {32'd0, ir64}, 64'(m_ret[1]));
  endtask

  task automatic cycle(input string pfx);
    model_step();
    @(posedge clk);
    #1;
    check_all(pfx);
  endtask

  task automatic rand_inputs();
    in_valid         = ($urandom_range(0, 3) != 0);
    in_regwrite      = $urandom_range(0, 1) == 1;
    in_rd            = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    in_wb_sel        = 2'($urandom);
    in_load_size     = 2'($urandom);
    in_load_unsigned = $urandom_range(0, 1) == 1;
    off              = 3'($urandom);
    alu = {$urandom, $urandom}; mem = {$urandom, $urandom};
    pc4 = {$urandom, $urandom}; imm = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // S1: signed/unsigned byte load from lane 2
    in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd3; in_wb_sel = 2'b01;
    mem = 64'h0000_0000_80FF_7F01; in_load_size = 2'b00; off = 3'd2; in_load_unsigned = 1'b0;
    cycle("s1_signed");
    check("s1_signed_const", {32'd0, d32}, 64'h0000_0000_FFFF_FFFF);
    in_load_unsigned = 1'b1;
    cycle("s1_unsigned");
    check("s1_unsigned_const", {32'd0, d32}, 64'h0000_0000_0000_00FF);

    // S2: 64-bit word load from upper half, then full-width load
    mem = 64'h9000_0000_1234_5678; in_load_size = 2'b10; off = 3'd4; in_load_unsigned = 1'b0;
    cycle("s2_word");
    check("s2_word_const", d64, 64'hFFFF_FFFF_9000_0000);
    in_load_size = 2'b11;
    cycle("s2_full");
    check("s2_full_const", d64, 64'h9000_0000_1234_5678);
    check("s2_full32_const", {32'd0, d32}, 64'h0000_0000_1234_5678);

    // S3: write to x0 retires but never asserts regwrite
    in_regwrite = 1'b1; in_rd = 5'd0; in_wb_sel = 2'b00; alu = 64'h1234;
    cycle("s3");
    check("s3_valid", {63'd0, v64}, 64'd1);
    check("s3_rw", {63'd0, rw64}, 64'd0);
    check("s3_data", d64, 64'h1234);

    // S4: capture rd=5, stall with changing inputs, flush while stalled
    in_rd = 5'd5; alu = 64'hABCD;
    cycle("s4_cap");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle("s4_stall");
    end
    check("s4_rd_held", {59'd0, rd32}, 64'd5);
    check("s4_data_held", d64, 64'hABCD);
    flush = 1'b1;
    cycle("s4_flush");
    check("s4_flush_valid", {63'd0, v32}, 64'd0);
    check("s4_flush_data", d64, 64'd0);
    stall = 1'b0; flush = 1'b0;

    // S5: 4-bit counter wraps 15 -> 0, then asynchronous reset between edges
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      cycle("s5_count");
    end
    check("s5_at15", {60'd0, ir32}, 64'd15);
    cycle("s5_wrap");
    check("s5_wrapped", {60'd0, ir32}, 64'd0);
    do_reset();

    // Randomized traffic with occasional stall/flush and resets
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand");
      if ($urandom_range(0, 99) == 0) begin
        stall = 1'b1; flush = 1'b1;
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
